// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline: control bundle,
// opcode constants and immediate-class encoding.
package pipe_pkg;

    // Decoded control bits carried from ID into EX.
    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // All-zero control word: an instruction that changes no architectural state.
    localparam ctrl_t CTRL_NOP = ctrl_t'(8'h00);

    // RV32I major opcodes seen by the decode control unit.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate class selected by the control unit.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_R = 2'b11
    } imm_sel_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection and stall generation for the ID/EX boundary.
// Purely combinational; the register bank consumes lu_o, the front end stall_o.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_alu_src_i,
    input  logic       id_mem_write_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       lu_o,
    output logic       stall_o
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // A load in EX whose destination feeds the instruction in ID. rs2 only
    // counts when it is really read: register-register ALU ops or stores
    // (stores read rs2 as write data even though the ALU uses the immediate).
    always_comb begin
        rs1_hit_s = (ex_rd_i == id_rs1_i);
        rs2_hit_s = (ex_rd_i == id_rs2_i) & (~id_alu_src_i | id_mem_write_i);
        if (ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) && id_valid_i) begin
            lu_o = rs1_hit_s | rs2_hit_s;
        end else begin
            lu_o = 1'b0;
        end
    end

    // Front-end stall: a hazard or downstream hold, unless a flush squashes it.
    always_comb begin
        if (flush_i) begin
            stall_o = 1'b0;
        end else begin
            stall_o = lu_o | hold_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RV32 core. Captures decoded
// control and operands, inserts a bubble on load-use, honours branch flush
// and downstream hold, and counts load-use bubbles with saturation.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  ctrl_t            id_ctrl_i,
    input  logic [1:0]       id_imm_sel_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic [2:0]       id_funct3_i,
    input  logic             id_funct7b5_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             ex_valid_o,
    output ctrl_t            ex_ctrl_o,
    output logic [1:0]       ex_imm_sel_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [2:0]       ex_funct3_o,
    output logic             ex_funct7b5_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic             valid_q,    valid_d;
    ctrl_t            ctrl_q,     ctrl_d;
    logic [1:0]       imm_sel_q,  imm_sel_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [4:0]       rs1_q,      rs1_d;
    logic [4:0]       rs2_q,      rs2_d;
    logic [4:0]       rd_q,       rd_d;
    logic [2:0]       funct3_q,   funct3_d;
    logic             funct7b5_q, funct7b5_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             lu_s;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hazard_detect u_hazard (
        .ex_valid_i     (valid_q),
        .ex_mem_read_i  (ctrl_q.mem_read),
        .ex_rd_i        (rd_q),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_alu_src_i   (id_ctrl_i.alu_src),
        .id_mem_write_i (id_ctrl_i.mem_write),
        .flush_i        (flush_i),
        .hold_i         (hold_i),
        .lu_o           (lu_s),
        .stall_o        (stall_o)
    );

    // Next-state priority: flush bubble, hold, load-use bubble, capture.
    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        imm_sel_d  = imm_sel_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        cnt_d      = cnt_q;
        if (flush_i || (!hold_i && lu_s)) begin
            // Bubble: data fields are don't-care but zeroed for determinism.
            valid_d    = 1'b0;
            ctrl_d     = CTRL_NOP;
            imm_sel_d  = 2'b00;
            pc_d       = {XLEN{1'b0}};
            rs1_data_d = {XLEN{1'b0}};
            rs2_data_d = {XLEN{1'b0}};
            imm_d      = {XLEN{1'b0}};
            rs1_d      = 5'd0;
            rs2_d      = 5'd0;
            rd_d       = 5'd0;
            funct3_d   = 3'd0;
            funct7b5_d = 1'b0;
            // Only load-use bubbles are counted; flush wins over a coincident hazard.
            if (!flush_i && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (hold_i) begin
            valid_d = valid_q;
        end else begin
            valid_d    = id_valid_i;
            ctrl_d     = id_valid_i ? id_ctrl_i : CTRL_NOP;
            imm_sel_d  = id_imm_sel_i;
            pc_d       = id_pc_i;
            rs1_data_d = id_rs1_data_i;
            rs2_data_d = id_rs2_data_i;
            imm_d      = id_imm_i;
            rs1_d      = id_rs1_i;
            rs2_d      = id_rs2_i;
            rd_d       = id_rd_i;
            funct3_d   = id_funct3_i;
            funct7b5_d = id_funct7b5_i;
        end
    end

    // Pipeline register bank and bubble counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            imm_sel_q  <= 2'b00;
            pc_q       <= {XLEN{1'b0}};
            rs1_data_q <= {XLEN{1'b0}};
            rs2_data_q <= {XLEN{1'b0}};
            imm_q      <= {XLEN{1'b0}};
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            funct3_q   <= 3'd0;
            funct7b5_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            imm_sel_q  <= imm_sel_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid_o    = valid_q;
    assign ex_ctrl_o     = ctrl_q;
    assign ex_imm_sel_o  = imm_sel_q;
    assign ex_pc_o       = pc_q;
    assign ex_rs1_data_o = rs1_data_q;
    assign ex_rs2_data_o = rs2_data_q;
    assign ex_imm_o      = imm_q;
    assign ex_rs1_o      = rs1_q;
    assign ex_rs2_o      = rs2_q;
    assign ex_rd_o       = rd_q;
    assign ex_funct3_o   = funct3_q;
    assign ex_funct7b5_o = funct7b5_q;
    assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table with a scoreboard queue,
// plus reset and reset-mid-stall sequences. A second instance with a 2-bit
// counter shares the stimulus to observe saturation.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam ctrl_t C_ADD  = ctrl_t'(8'b0_0_1_0_0_0_10);
    localparam ctrl_t C_LW   = ctrl_t'(8'b1_1_1_1_0_0_00);
    localparam ctrl_t C_ADDI = ctrl_t'(8'b1_0_1_0_0_0_10);
    localparam ctrl_t C_SW   = ctrl_t'(8'b1_0_0_0_1_0_00);

    typedef enum logic [1:0] {K_CAP, K_BUB, K_KEEP} kind_e;

    typedef struct {
        logic       flush;
        logic       hold;
        logic       valid;
        ctrl_t      ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       exp_stall;
        kind_e      kind;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        logic        valid;
        ctrl_t       ctrl;
        logic [1:0]  imm_sel;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid_i = 1'b0;
    ctrl_t id_ctrl_i = CTRL_NOP;
    logic [1:0] id_imm_sel_i = 2'b00;
    logic [31:0] id_pc_i = 32'd0, id_rs1_data_i = 32'd0, id_rs2_data_i = 32'd0, id_imm_i = 32'd0;
    logic [4:0] id_rs1_i = 5'd0, id_rs2_i = 5'd0, id_rd_i = 5'd0;
    logic [2:0] id_funct3_i = 3'd0;
    logic id_funct7b5_i = 1'b0, flush_i = 1'b0, hold_i = 1'b0;

    logic ex_valid_o, ex_funct7b5_o, stall_o;
    ctrl_t ex_ctrl_o;
    logic [1:0] ex_imm_sel_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [2:0] ex_funct3_o;
    logic [15:0] bubble_cnt_o;

    logic s_valid, s_f7, s_stall;
    ctrl_t s_ctrl;
    logic [1:0] s_imm_sel;
    logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
    logic [4:0] s_rs1, s_rs2, s_rd;
    logic [2:0] s_f3;
    logic [1:0] s_cnt;

    int checks = 0;
    int failures = 0;
    exp_t sb_q[$];
    exp_t m;
    vec_t vecs[30];

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_imm_sel_i(id_imm_sel_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
        .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct3_i(id_funct3_i),
        .id_funct7b5_i(id_funct7b5_i), .flush_i(flush_i), .hold_i(hold_i),
        .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o), .ex_imm_sel_o(ex_imm_sel_o),
        .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
        .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o), .stall_o(stall_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_imm_sel_i(id_imm_sel_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
        .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct3_i(id_funct3_i),
        .id_funct7b5_i(id_funct7b5_i), .flush_i(flush_i), .hold_i(hold_i),
        .ex_valid_o(s_valid), .ex_ctrl_o(s_ctrl), .ex_imm_sel_o(s_imm_sel),
        .ex_pc_o(s_pc), .ex_rs1_data_o(s_rs1d), .ex_rs2_data_o(s_rs2d),
        .ex_imm_o(s_imm), .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd),
        .ex_funct3_o(s_f3), .ex_funct7b5_o(s_f7), .stall_o(s_stall),
        .bubble_cnt_o(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic ho, input logic va, input ctrl_t c,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic st, input kind_e k, input int cnt);
        vec_t v;
        v.flush = fl; v.hold = ho; v.valid = va; v.ctrl = c;
        v.rs1 = r1; v.rs2 = r2; v.rd = rd;
        v.exp_stall = st; v.kind = k; v.exp_cnt = cnt;
        return v;
    endfunction

    function automatic exp_t zero_exp(input int cnt);
        exp_t e;
        e.valid = 1'b0; e.ctrl = CTRL_NOP; e.imm_sel = 2'b00; e.pc = 32'd0;
        e.rs1d = 32'd0; e.rs2d = 32'd0; e.imm = 32'd0; e.rs1 = 5'd0; e.rs2 = 5'd0;
        e.rd = 5'd0; e.f3 = 3'd0; e.f7 = 1'b0; e.cnt = cnt;
        return e;
    endfunction

    // Drive one ID-stage instruction; data fields are derived from the index.
    task automatic apply(input vec_t v, input int i);
        flush_i       = v.flush;
        hold_i        = v.hold;
        id_valid_i    = v.valid;
        id_ctrl_i     = v.ctrl;
        id_rs1_i      = v.rs1;
        id_rs2_i      = v.rs2;
        id_rd_i       = v.rd;
        id_pc_i       = 32'h0000_1000 + 32'(i * 4);
        id_rs1_data_i = 32'hA500_0000 + 32'(i);
        id_rs2_data_i = 32'hB600_0000 + 32'(i * 3);
        id_imm_i      = 32'h0000_0100 + 32'(i);
        id_imm_sel_i  = 2'(i);
        id_funct3_i   = 3'(i + 1);
        id_funct7b5_i = (i % 2 == 1) ? 1'b1 : 1'b0;
    endtask

    task automatic compare(input exp_t e, input string tag);
        chk({tag, ".valid"},   {31'd0, ex_valid_o},    {31'd0, e.valid});
        chk({tag, ".ctrl"},    {24'd0, ex_ctrl_o},     {24'd0, e.ctrl});
        chk({tag, ".rd"},      {27'd0, ex_rd_o},       {27'd0, e.rd});
        chk({tag, ".rs1data"}, ex_rs1_data_o,          e.rs1d);
        chk({tag, ".misc"},    {ex_rs1_o, ex_rs2_o, ex_imm_sel_o, ex_funct3_o, ex_funct7b5_o, 16'd0},
                               {e.rs1, e.rs2, e.imm_sel, e.f3, e.f7, 16'd0});
        chk({tag, ".data"},    ex_pc_o ^ ex_rs2_data_o ^ ex_imm_o, e.pc ^ e.rs2d ^ e.imm);
        chk({tag, ".cnt"},     {16'd0, bubble_cnt_o},  32'(e.cnt));
        chk({tag, ".satcnt"},  {30'd0, s_cnt},         32'((e.cnt > 3) ? 3 : e.cnt));
    endtask

    initial begin
        exp_t e;
        // add x3,x1,x2 / lw x5 / add x6,x5,x1 ... (flush, hold, valid, ctrl, rs1, rs2, rd, stall, kind, cnt)
        vecs[0]  = mk(0, 0, 1, C_ADD,  5'd1,  5'd2,  5'd3,  0, K_CAP,  0);
        vecs[1]  = mk(0, 0, 1, C_LW,   5'd1,  5'd0,  5'd5,  0, K_CAP,  0);
        vecs[2]  = mk(0, 0, 1, C_ADD,  5'd5,  5'd1,  5'd6,  1, K_BUB,  1);
        vecs[3]  = mk(0, 0, 1, C_ADD,  5'd5,  5'd1,  5'd6,  0, K_CAP,  1);
        vecs[4]  = mk(0, 0, 1, C_LW,   5'd2,  5'd0,  5'd0,  0, K_CAP,  1);
        vecs[5]  = mk(0, 0, 1, C_ADD,  5'd0,  5'd0,  5'd8,  0, K_CAP,  1);
        vecs[6]  = mk(0, 0, 1, C_LW,   5'd1,  5'd0,  5'd5,  0, K_CAP,  1);
        vecs[7]  = mk(0, 0, 1, C_ADDI, 5'd1,  5'd5,  5'd7,  0, K_CAP,  1);
        vecs[8]  = mk(0, 0, 1, C_LW,   5'd1,  5'd0,  5'd5,  0, K_CAP,  1);
        vecs[9]  = mk(0, 0, 1, C_SW,   5'd1,  5'd5,  5'd0,  1, K_BUB,  2);
        vecs[10] = mk(0, 0, 1, C_SW,   5'd1,  5'd5,  5'd0,  0, K_CAP,  2);
        vecs[11] = mk(0, 0, 1, C_LW,   5'd2,  5'd0,  5'd9,  0, K_CAP,  2);
        vecs[12] = mk(0, 0, 1, C_ADD,  5'd1,  5'd9,  5'd10, 1, K_BUB,  3);
        vecs[13] = mk(0, 0, 1, C_ADD,  5'd1,  5'd9,  5'd10, 0, K_CAP,  3);
        vecs[14] = mk(0, 0, 1, C_LW,   5'd1,  5'd0,  5'd4,  0, K_CAP,  3);
        vecs[15] = mk(1, 0, 1, C_ADD,  5'd4,  5'd4,  5'd11, 0, K_BUB,  3);
        vecs[16] = mk(1, 1, 1, C_ADD,  5'd4,  5'd4,  5'd11, 0, K_BUB,  3);
        vecs[17] = mk(0, 0, 1, C_ADD,  5'd1,  5'd2,  5'd12, 0, K_CAP,  3);
        vecs[18] = mk(0, 1, 1, C_LW,   5'd3,  5'd0,  5'd13, 1, K_KEEP, 3);
        vecs[19] = mk(0, 1, 1, C_LW,   5'd3,  5'd0,  5'd13, 1, K_KEEP, 3);
        vecs[20] = mk(0, 1, 1, C_LW,   5'd3,  5'd0,  5'd13, 1, K_KEEP, 3);
        vecs[21] = mk(0, 0, 1, C_LW,   5'd3,  5'd0,  5'd13, 0, K_CAP,  3);
        vecs[22] = mk(0, 1, 1, C_ADD,  5'd13, 5'd1,  5'd14, 1, K_KEEP, 3);
        vecs[23] = mk(0, 0, 1, C_ADD,  5'd13, 5'd1,  5'd14, 1, K_BUB,  4);
        vecs[24] = mk(0, 0, 1, C_ADD,  5'd13, 5'd1,  5'd14, 0, K_CAP,  4);
        vecs[25] = mk(0, 0, 0, C_LW,   5'd14, 5'd0,  5'd15, 0, K_CAP,  4);
        vecs[26] = mk(0, 0, 1, C_LW,   5'd2,  5'd0,  5'd15, 0, K_CAP,  4);
        vecs[27] = mk(0, 0, 0, C_ADD,  5'd15, 5'd0,  5'd16, 0, K_CAP,  4);
        vecs[28] = mk(0, 0, 1, C_LW,   5'd2,  5'd0,  5'd15, 0, K_CAP,  4);
        vecs[29] = mk(0, 0, 1, C_ADD,  5'd15, 5'd0,  5'd16, 1, K_BUB,  5);

        // Reset for two cycles with random ID-side inputs.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            id_valid_i = 1'($urandom); id_ctrl_i = ctrl_t'($urandom);
            id_rs1_i = 5'($urandom); id_rs2_i = 5'($urandom); id_rd_i = 5'($urandom);
            id_rs1_data_i = $urandom; id_pc_i = $urandom;
        end
        @(posedge clk); #1;
        m = zero_exp(0);
        compare(m, "reset");
        chk("reset.stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;

        // Table-driven sequence through the scoreboard.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            apply(vecs[i], i);
            #1;
            chk($sformatf("v%0d.stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
            case (vecs[i].kind)
                K_CAP: begin
                    e.valid = vecs[i].valid;
                    e.ctrl = vecs[i].valid ? vecs[i].ctrl : CTRL_NOP;
                    e.imm_sel = id_imm_sel_i; e.pc = id_pc_i;
                    e.rs1d = id_rs1_data_i; e.rs2d = id_rs2_data_i; e.imm = id_imm_i;
                    e.rs1 = vecs[i].rs1; e.rs2 = vecs[i].rs2; e.rd = vecs[i].rd;
                    e.f3 = id_funct3_i; e.f7 = id_funct7b5_i;
                end
                K_BUB:   e = zero_exp(0);
                default: e = m;
            endcase
            e.cnt = vecs[i].exp_cnt;
            m = e;
            sb_q.push_back(e);
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                chk("scoreboard.empty", 32'd0, 32'd1);
            end else begin
                compare(sb_q.pop_front(), $sformatf("v%0d", i));
            end
        end

        // Reset arriving while a load-use stall is pending.
        @(negedge clk);
        apply(mk(0, 0, 1, C_LW, 5'd1, 5'd0, 5'd5, 0, K_CAP, 5), 40);
        @(negedge clk);
        apply(mk(0, 0, 1, C_ADD, 5'd5, 5'd1, 5'd6, 1, K_BUB, 5), 41);
        #1;
        chk("rststall.pre", {31'd0, stall_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rststall.stall", {31'd0, stall_o}, 32'd0);
        compare(zero_exp(0), "rststall");
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
